// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light timebase and controller.
package traffic_pkg;

   typedef enum logic {PH_LONG = 1'b0, PH_SHORT = 1'b1} phase_e;

   localparam int unsigned DEF_LONG_S  = 45;
   localparam int unsigned DEF_SHORT_S = 15;

   // Two-digit BCD of a value in 0..99.
   function automatic logic [7:0] to_bcd(input int v);
      int tens;
      int ones;
      tens = (v / 10) % 10;
      ones = v % 10;
      return {tens[3:0], ones[3:0]};
   endfunction

endpackage

// File: rtl/traffic_prescaler.sv
// Divides clk1 down to a one-cycle tick once every CLK_HZ cycles.
// tick is combinational and suppressed while pause is high.
module traffic_prescaler #(
   parameter int unsigned CLK_HZ = 100_000_000
) (
   input  logic clk1,
   input  logic clr,
   input  logic pause,
   output logic tick
);

   localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

   logic [PW-1:0] cnt;

   assign tick = !pause && (cnt == LAST);

   // Free-running modulo-CLK_HZ counter, frozen while paused.
   always_ff @(posedge clk1 or posedge clr) begin
      if (clr) begin
         cnt <= '0;
      end else if (!pause) begin
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/traffic_timer.sv
// Traffic-light timebase: alternating LONG/SHORT second-counting phases with
// one-cycle completion strobes _45s/_15s.
// Optional macro TRAFFIC_COUNTDOWN_EN adds the BCD remain output.
module traffic_timer
   import traffic_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned LONG_S  = DEF_LONG_S,
   parameter int unsigned SHORT_S = DEF_SHORT_S
) (
   input  logic       clk1,
   input  logic       clr,
   input  logic       pause,
   output logic       _45s,
   output logic       _15s
`ifdef TRAFFIC_COUNTDOWN_EN
   ,
   output logic [7:0] remain
`endif
);

   localparam int unsigned MAX_S = (LONG_S > SHORT_S) ? LONG_S : SHORT_S;
   localparam int unsigned SW    = (MAX_S > 1) ? $clog2(MAX_S) : 1;
   localparam logic [SW-1:0] LONG_LAST  = SW'(LONG_S - 1);
   localparam logic [SW-1:0] SHORT_LAST = SW'(SHORT_S - 1);

   logic          tick;
   logic          last_sec;
   logic          done;
   logic [SW-1:0] sec_cnt;
   phase_e        phase;

   traffic_prescaler #(
      .CLK_HZ (CLK_HZ)
   ) u_prescaler (
      .clk1  (clk1),
      .clr   (clr),
      .pause (pause),
      .tick  (tick)
   );

   assign last_sec = (phase == PH_LONG) ? (sec_cnt == LONG_LAST) : (sec_cnt == SHORT_LAST);
   assign done     = tick && last_sec;

   // Second counter, phase toggle and registered completion strobes.
   always_ff @(posedge clk1 or posedge clr) begin
      if (clr) begin
         sec_cnt <= '0;
         phase   <= PH_LONG;
         _45s    <= 1'b0;
         _15s    <= 1'b0;
      end else begin
         _45s <= done && (phase == PH_LONG);
         _15s <= done && (phase == PH_SHORT);
         if (tick) begin
            if (last_sec) begin
               sec_cnt <= '0;
               phase   <= (phase == PH_LONG) ? PH_SHORT : PH_LONG;
            end else begin
               sec_cnt <= sec_cnt + 1'b1;
            end
         end
      end
   end

`ifdef TRAFFIC_COUNTDOWN_EN
   logic [7:0] remain_nxt;
   int         n_cur;

   // Seconds left after this tick; a wrap loads the next phase's full length.
   always_comb begin
      remain_nxt = remain;
      n_cur      = (phase == PH_LONG) ? int'(LONG_S) : int'(SHORT_S);
      if (tick) begin
         if (last_sec) begin
            remain_nxt = to_bcd((phase == PH_LONG) ? int'(SHORT_S) : int'(LONG_S));
         end else begin
            remain_nxt = to_bcd(n_cur - int'(sec_cnt) - 1);
         end
      end
   end

   // Countdown register, updated on the same edge as sec_cnt/phase.
   always_ff @(posedge clk1 or posedge clr) begin
      if (clr) begin
         remain <= to_bcd(int'(LONG_S));
      end else begin
         remain <= remain_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: CLK_HZ=4, LONG_S=45, SHORT_S=15, plus a
// CLK_HZ=1, LONG_S=1, SHORT_S=1 instance for the degenerate alternation case.
module tb_traffic_timer;

   logic clk1 = 1'b0;
   logic clr  = 1'b1;
   logic pause = 1'b0;
   logic s45, s15, f45, f15;
`ifdef TRAFFIC_COUNTDOWN_EN
   logic [7:0] rem, frem;
`endif

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   always #5 clk1 = ~clk1;

   traffic_timer #(
      .CLK_HZ  (4),
      .LONG_S  (45),
      .SHORT_S (15)
   ) u_dut (
      .clk1   (clk1),
      .clr    (clr),
      .pause  (pause),
      ._45s   (s45),
      ._15s   (s15)
`ifdef TRAFFIC_COUNTDOWN_EN
      ,
      .remain (rem)
`endif
   );

   traffic_timer #(
      .CLK_HZ  (1),
      .LONG_S  (1),
      .SHORT_S (1)
   ) u_fast (
      .clk1   (clk1),
      .clr    (clr),
      .pause  (pause),
      ._45s   (f45),
      ._15s   (f15)
`ifdef TRAFFIC_COUNTDOWN_EN
      ,
      .remain (frem)
`endif
   );

   typedef struct {
      int         at_edge;
      logic       e45;
      logic       e15;
      logic [7:0] erem;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // One rising edge, then sample 1 ns later.
   task automatic step();
      @(posedge clk1);
      #1;
      edge_n++;
   endtask

   task automatic release_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
      edge_n = 0;
   endtask

   // Bounded wait for the next strobe of either kind.
   task automatic wait_strobe(input int max_edges, output int at_edge, output logic is45);
      at_edge = -1;
      is45    = 1'b0;
      for (int i = 0; i < max_edges; i++) begin
         step();
         if (s45 || s15) begin
            at_edge = edge_n;
            is45    = s45;
            break;
         end
      end
      if (at_edge < 0) begin
         checks++;
         failures++;
         $display("FAIL strobe_timeout: got none expected a strobe within %0d edges", max_edges);
      end
   endtask

   initial begin
      int   n45, n15, both, at;
      logic k45;

      tbl[0]  = '{1,   1'b0, 1'b0, 8'h45};
      tbl[1]  = '{3,   1'b0, 1'b0, 8'h45};
      tbl[2]  = '{4,   1'b0, 1'b0, 8'h44};
      tbl[3]  = '{179, 1'b0, 1'b0, 8'h01};
      tbl[4]  = '{180, 1'b1, 1'b0, 8'h15};
      tbl[5]  = '{181, 1'b0, 1'b0, 8'h15};
      tbl[6]  = '{239, 1'b0, 1'b0, 8'h01};
      tbl[7]  = '{240, 1'b0, 1'b1, 8'h45};
      tbl[8]  = '{241, 1'b0, 1'b0, 8'h45};
      tbl[9]  = '{419, 1'b0, 1'b0, 8'h01};
      tbl[10] = '{420, 1'b1, 1'b0, 8'h15};
      tbl[11] = '{421, 1'b0, 1'b0, 8'h15};

      // Reset state held while clr is high.
      repeat (3) step();
      check("rst_45s", 32'(s45), 32'd0);
      check("rst_15s", 32'(s15), 32'd0);
      check("rst_fast_45s", 32'(f45), 32'd0);
`ifdef TRAFFIC_COUNTDOWN_EN
      check("rst_remain", 32'(rem), 32'h45);
`endif

      // Phase sequence from reset release.
      clr = 1'b0;
      edge_n = 0;
      n45 = 0;
      n15 = 0;
      both = 0;
      for (int e = 1; e <= 430; e++) begin
         step();
         if (s45) n45++;
         if (s15) n15++;
         if (s45 && s15) both++;
         foreach (tbl[k]) begin
            if (tbl[k].at_edge == edge_n) begin
               check("seq_45s", 32'(s45), 32'(tbl[k].e45));
               check("seq_15s", 32'(s15), 32'(tbl[k].e15));
`ifdef TRAFFIC_COUNTDOWN_EN
               check("seq_remain", 32'(rem), 32'(tbl[k].erem));
`endif
            end
         end
      end
      check("seq_count_45s", 32'(n45), 32'd2);
      check("seq_count_15s", 32'(n15), 32'd1);
      check("seq_coincident", 32'(both), 32'd0);

      // Async clr while _45s is high, then a full LONG phase from scratch.
      release_clr();
      while (edge_n < 180) step();
      check("clr_pre_45s", 32'(s45), 32'd1);
      #2 clr = 1'b1;
      #1;
      check("clr_async_45s", 32'(s45), 32'd0);
`ifdef TRAFFIC_COUNTDOWN_EN
      check("clr_async_remain", 32'(rem), 32'h45);
`endif
      step();
      clr = 1'b0;
      edge_n = 0;
      wait_strobe(200, at, k45);
      check("clr_next_45s_edge", 32'(at), 32'd180);
      check("clr_next_is_45s", 32'(k45), 32'd1);

      // Pause for 37 edges starting after edge 50.
      release_clr();
      while (edge_n < 50) step();
      pause = 1'b1;
      n45 = 0;
      for (int i = 0; i < 37; i++) begin
         step();
         if (s45 || s15) n45++;
      end
      check("pause_no_strobe", 32'(n45), 32'd0);
`ifdef TRAFFIC_COUNTDOWN_EN
      check("pause_remain_frozen", 32'(rem), 32'h33);
`endif
      pause = 1'b0;
      wait_strobe(300, at, k45);
      check("pause_45s_edge", 32'(at), 32'd217);
      check("pause_is_45s", 32'(k45), 32'd1);
      // A registered strobe still clears under pause; 10 paused edges delay _15s.
      pause = 1'b1;
      step();
      check("pause_strobe_clears", 32'(s45), 32'd0);
      repeat (9) step();
      pause = 1'b0;
      wait_strobe(100, at, k45);
      check("pause_15s_edge", 32'(at), 32'd287);
      check("pause_is_15s", 32'(k45), 32'd0);

      // Degenerate timing: strobes alternate every edge.
      release_clr();
      for (int e = 1; e <= 8; e++) begin
         step();
         check("fast_45s", 32'(f45), 32'(e % 2));
         check("fast_15s", 32'(f15), 32'((e + 1) % 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
